// File: rtl/led_indicator_pkg.sv
// rtl/led_indicator_pkg.sv - shared types and helpers for the LED indicator controller
package led_indicator_pkg;

    typedef enum logic [2:0] {
        MODE_OFF     = 3'd0,
        MODE_ON      = 3'd1,
        MODE_BLINK   = 3'd2,
        MODE_HEART   = 3'd3,
        MODE_ONESHOT = 3'd4
    } mode_e;

    function automatic int calc_div(input int clk_freq, input int tick_hz);
        return clk_freq / tick_hz;
    endfunction

    function automatic int tick_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // Encodings 5..7 are not valid modes and collapse to OFF.
    function automatic mode_e decode_mode(input logic [2:0] m);
        return (m > 3'd4) ? MODE_OFF : mode_e'(m);
    endfunction

endpackage

// File: rtl/led_indicator_ctrl_if.sv
// rtl/led_indicator_ctrl_if.sv - single-cycle configuration write port and phase sync
interface led_indicator_ctrl_if #(
    parameter int NUM_CH   = 8,
    parameter int PERIOD_W = 16,
    parameter int PWM_BITS = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [2:0]          cfg_mode;
    logic [PERIOD_W-1:0] cfg_period;
    logic [PWM_BITS-1:0] cfg_duty;
    logic                sync;

    modport master (
        output cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_duty, sync
    );

    modport slave (
        input cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_duty, sync
    );

endinterface

// File: rtl/led_indicator_channel.sv
// rtl/led_indicator_channel.sv - one LED channel: mode/period/duty state, phase counter, output register
module led_indicator_channel
    import led_indicator_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int PWM_BITS = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tick_i,
    input  logic                sync_i,
    input  logic                we_i,
    input  logic [2:0]          mode_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_o,
    output logic                done_o
);

    mode_e               mode_q, mode_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                led_q, led_d;
    logic                done_q, done_d;

    logic                at_end;
    logic                expire;
    logic                phase_on;
    logic [PERIOD_W+1:0] p3_8;

    always_comb begin
        at_end = (period_q == '0) || (cnt_q == period_q - PERIOD_W'(1));
        // A sync cycle swallows the tick, so a ONESHOT cannot expire on it either.
        expire = tick_i && !sync_i && (mode_q == MODE_ONESHOT) && at_end;
        p3_8   = ({1'b0, period_q, 1'b0} + {2'b00, period_q}) >> 3;

        phase_on = 1'b0;
        case (mode_q)
            MODE_ON:      phase_on = 1'b1;
            MODE_BLINK:   phase_on = (period_q < PERIOD_W'(2)) || (cnt_q < (period_q >> 1));
            MODE_HEART:   phase_on = (period_q < PERIOD_W'(8))
                                  || (cnt_q < (period_q >> 3))
                                  || ((cnt_q >= (period_q >> 2)) && ({2'b00, cnt_q} < p3_8));
            MODE_ONESHOT: phase_on = 1'b1;
            default:      phase_on = 1'b0;
        endcase

        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        cnt_d    = cnt_q;

        if (we_i) begin
            mode_d   = decode_mode(mode_i);
            period_d = period_i;
            duty_d   = duty_i;
            cnt_d    = '0;
        end else begin
            if (expire) begin
                mode_d = MODE_OFF;
            end
            if (sync_i) begin
                cnt_d = '0;
            end else if (tick_i) begin
                cnt_d = at_end ? '0 : cnt_q + PERIOD_W'(1);
            end
        end

        led_d  = phase_on && (pwm_cnt_i < duty_q);
        done_d = expire && !we_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q   <= MODE_OFF;
            period_q <= '0;
            duty_q   <= '0;
            cnt_q    <= '0;
            led_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
            done_q   <= done_d;
        end
    end

    assign led_o  = led_q;
    assign done_o = done_q;

endmodule

// File: rtl/led_indicator_ctrl.sv
// rtl/led_indicator_ctrl.sv - multi-channel LED controller top: prescaler, shared PWM counter, write decode
module led_indicator_ctrl
    import led_indicator_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int CLK_FREQ = 25_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int PERIOD_W = 16,
    parameter int PWM_BITS = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    led_indicator_ctrl_if.slave     cfg,
    output logic [NUM_CH-1:0]       led_o,
    output logic [NUM_CH-1:0]       done_o
);

    localparam int DIV    = calc_div(CLK_FREQ, TICK_HZ);
    localparam int TICK_W = tick_w(DIV);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (DIV < 2) begin : g_div_chk
        $error("led_indicator_ctrl: CLK_FREQ/TICK_HZ must be at least 2");
    end
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_ch_chk
        $error("led_indicator_ctrl: NUM_CH must be in 1..32");
    end

    logic [TICK_W-1:0]   presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                tick;

    always_comb begin
        tick    = (presc_q == TICK_W'(DIV - 1));
        presc_d = tick ? '0 : presc_q + TICK_W'(1);
        pwm_d   = pwm_q + PWM_BITS'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            pwm_q   <= '0;
        end else begin
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
        end
    end

    // Channel indices with no instance never match, so out-of-range writes drop out.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic we_ch;
        assign we_ch = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

        led_indicator_channel #(
            .PERIOD_W (PERIOD_W),
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .tick_i    (tick),
            .sync_i    (cfg.sync),
            .we_i      (we_ch),
            .mode_i    (cfg.cfg_mode),
            .period_i  (cfg.cfg_period),
            .duty_i    (cfg.cfg_duty),
            .pwm_cnt_i (pwm_q),
            .led_o     (led_o[i]),
            .done_o    (done_o[i])
        );
    end

endmodule

// File: tb/tb_led_indicator_ctrl.sv
// tb/tb_led_indicator_ctrl.sv - self-checking bench for led_indicator_ctrl against a behavioural model
module tb_led_indicator_ctrl;

    localparam int NUM_CH   = 5;
    localparam int CLK_FREQ = 100;
    localparam int TICK_HZ  = 10;
    localparam int PERIOD_W = 16;
    localparam int PWM_BITS = 2;
    localparam int DIV      = CLK_FREQ / TICK_HZ;
    localparam int PWM_MOD  = 1 << PWM_BITS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] led_o;
    logic [NUM_CH-1:0] done_o;

    led_indicator_ctrl_if #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .PWM_BITS(PWM_BITS)) cfg_if ();

    led_indicator_ctrl #(
        .NUM_CH   (NUM_CH),
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ),
        .PERIOD_W (PERIOD_W),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .cfg    (cfg_if),
        .led_o  (led_o),
        .done_o (done_o)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state: integers, with edges counted since reset release.
    int m_mode[NUM_CH];
    int m_p[NUM_CH];
    int m_d[NUM_CH];
    int m_cnt[NUM_CH];
    int k;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, k);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c] = 0; m_p[c] = 0; m_d[c] = 0; m_cnt[c] = 0;
        end
        k = 0;
    endtask

    function automatic bit model_on(input int c);
        int p = m_p[c];
        int n = m_cnt[c];
        case (m_mode[c])
            1: return 1'b1;
            2: return (p < 2) || (n < p / 2);
            3: return (p < 8) || (n < p / 8) || ((n >= p / 4) && (n < (3 * p) / 8));
            4: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_tick();
        return (k % DIV) == DIV - 1;
    endfunction

    function automatic bit is_expiry(input int c);
        return is_tick() && (m_mode[c] == 4) && ((m_p[c] == 0) || (m_cnt[c] == m_p[c] - 1));
    endfunction

    // Drive one cycle of inputs (called at a negedge), advance the model, check after the edge.
    task automatic cyc(input bit we, input int ch, input int md, input int p, input int d, input bit sy);
        logic [NUM_CH-1:0] exp_led;
        logic [NUM_CH-1:0] exp_done;
        bit tick;
        int pwm;
        cfg_if.cfg_we     = we;
        cfg_if.cfg_ch     = 3'(ch);
        cfg_if.cfg_mode   = 3'(md);
        cfg_if.cfg_period = 16'(p);
        cfg_if.cfg_duty   = 2'(d);
        cfg_if.sync       = sy;
        tick = is_tick();
        pwm  = k % PWM_MOD;
        for (int c = 0; c < NUM_CH; c++) begin
            bit ends;
            exp_led[c]  = model_on(c) && (pwm < m_d[c]);
            exp_done[c] = 1'b0;
            ends = (m_p[c] == 0) || (m_cnt[c] == m_p[c] - 1);
            if (we && ((ch % 8) == c)) begin
                m_mode[c] = (md > 4) ? 0 : md;
                m_p[c]    = p;
                m_d[c]    = d;
                m_cnt[c]  = 0;
            end else if (sy) begin
                m_cnt[c] = 0;
            end else if (tick) begin
                if (m_mode[c] == 4 && ends) begin
                    m_mode[c]   = 0;
                    exp_done[c] = 1'b1;
                end
                m_cnt[c] = ends ? 0 : m_cnt[c] + 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        k++;
        cfg_if.cfg_we = 1'b0;
        cfg_if.sync   = 1'b0;
        check_eq("led_o", 32'(led_o), 32'(exp_led));
        check_eq("done_o", 32'(done_o), 32'(exp_done));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int lit;
        int dn;
        bit hit;
        cfg_if.cfg_we = 0; cfg_if.cfg_ch = 0; cfg_if.cfg_mode = 0;
        cfg_if.cfg_period = 0; cfg_if.cfg_duty = 0; cfg_if.sync = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_led", 32'(led_o), 0);
        rst_n = 1'b1;

        // Reset state held for 200 cycles
        idle(200);

        // ch0 BLINK P=4 D=3: steady-state 40-cycle window holds 15 lit cycles
        cyc(1, 0, 2, 4, 3, 0);
        idle(40);
        lit = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            lit += int'(led_o[0]);
        end
        check_eq("blink_lit", 32'(lit), 15);

        // ch1 ONESHOT P=3 D=3: exactly one done pulse, then dark
        cyc(1, 1, 4, 3, 3, 0);
        dn = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            dn += int'(done_o[1]);
        end
        check_eq("oneshot_done", 32'(dn), 1);
        check_eq("oneshot_dark", 32'(led_o[1]), 0);

        // ch2 HEART P=16 then P=4 (steady on)
        cyc(1, 2, 3, 16, 3, 0);
        idle(200);
        cyc(1, 2, 3, 4, 3, 0);
        lit = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            lit += int'(led_o[2]);
        end
        check_eq("heart_p4_lit", 32'(lit), 30);

        // sync together with a write to ch3
        cyc(1, 3, 1, 0, 3, 1);
        idle(10);

        // write on ch1's expiry tick suppresses done
        cyc(1, 1, 4, 2, 3, 0);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (is_expiry(1)) begin
                cyc(1, 1, 1, 0, 2, 0);
                check_eq("expiry_write_done", 32'(done_o[1]), 0);
                hit = 1;
            end else begin
                cyc(0, 0, 0, 0, 0, 0);
            end
        end
        check_eq("expiry_found", 32'(hit), 1);
        idle(20);

        // out-of-range channel index is ignored
        cyc(1, 6, 1, 0, 3, 0);
        idle(10);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit we = ($urandom_range(7) == 0);
            bit sy = ($urandom_range(49) == 0);
            cyc(we, $urandom_range(7), $urandom_range(7), $urandom_range(20),
                $urandom_range(3), sy);
        end

        // async reset between edges while ch3 is lit
        cyc(1, 3, 1, 0, 3, 0);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            if (led_o[3]) hit = 1;
        end
        check_eq("async_pre_lit", 32'(hit), 1);
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst_led", 32'(led_o), 0);
        check_eq("async_rst_done", 32'(done_o), 0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        idle(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
